// File: rtl/mux2_arb_pkg.sv
// Shared definitions for the two-requester mux arbiter: FSM state encoding
// and the default hold limit.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    localparam int HOLD_MAX_DEFAULT = 4;

endpackage

// File: rtl/mux2_arb_mux.sv
// Existing single-bit 2:1 multiplexer used as the shared datapath of the arbiter.
// s=0 passes I0, s=1 passes I1.
module MUX2T1_1 (
    input  logic I0,
    input  logic I1,
    input  logic s,
    output logic out
);

    assign out = s ? I1 : I0;

endmodule

// File: rtl/mux2_arb.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux datapath.
// Define MUX2_ARB_HOLD_LIMIT_EN to compile in the hold counter and forced hand-over.
module mux2_arb
    import mux2_arb_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic I0,
    input  logic I1,
    output logic gnt0,
    output logic gnt1,
    output logic s,
    output logic out,
    output logic valid
);

    state_t state;
    state_t next_state;
    logic   last_gnt;
    logic   hold_expired;

`ifdef MUX2_ARB_HOLD_LIMIT_EN
    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    logic [3:0] hold_cnt;

    // Counts granted cycles of the current grant; restarts at 1 whenever a new grant begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 4'd0;
        end else if (next_state == IDLE) begin
            hold_cnt <= 4'd0;
        end else if (next_state != state) begin
            hold_cnt <= 4'd1;
        end else if (hold_cnt != HOLD_LIM) begin
            hold_cnt <= hold_cnt + 4'd1;
        end
    end

    assign hold_expired = (hold_cnt == HOLD_LIM);
`else
    assign hold_expired = 1'b0;
`endif

    // last_gnt remembers who was granted most recently, so a tie in IDLE goes to the other side.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    next_state = last_gnt ? G0 : G1;
                end else if (req0) begin
                    next_state = G0;
                end else if (req1) begin
                    next_state = G1;
                end
            end
            G0: begin
                if (!req0) begin
                    next_state = req1 ? G1 : IDLE;
                end else if (hold_expired && req1) begin
                    next_state = G1;
                end
            end
            G1: begin
                if (!req1) begin
                    next_state = req0 ? G0 : IDLE;
                end else if (hold_expired && req0) begin
                    next_state = G0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Select holds its last value while idle so the datapath does not toggle needlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            s        <= 1'b0;
            valid    <= 1'b0;
        end else begin
            state <= next_state;
            valid <= (next_state != IDLE);
            if (next_state == G0) begin
                last_gnt <= 1'b0;
                s        <= 1'b0;
            end else if (next_state == G1) begin
                last_gnt <= 1'b1;
                s        <= 1'b1;
            end
        end
    end

    assign gnt0 = (state == G0);
    assign gnt1 = (state == G1);

    MUX2T1_1 u_mux (
        .I0  (I0),
        .I1  (I1),
        .s   (s),
        .out (out)
    );

endmodule

// File: tb/tb_mux2_arb.sv
// Table-driven self-checking bench for mux2_arb; expectations follow whichever
// build of MUX2_ARB_HOLD_LIMIT_EN is compiled.
module tb_mux2_arb;

    typedef struct {
        logic rst;
        logic r0;
        logic r1;
        logic i0;
        logic i1;
        logic g0;
        logic g1;
        logic s;
        logic v;
    } vec_t;

    logic clk;
    logic rst;
    logic req0;
    logic req1;
    logic I0;
    logic I1;
    logic gnt0;
    logic gnt1;
    logic s;
    logic out;
    logic valid;

    vec_t       tbl[$];
    logic [4:0] expQ[$];
    int         passed;
    int         total;

    mux2_arb #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .I0    (I0),
        .I1    (I1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .s     (s),
        .out   (out),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(logic rst_v, logic r0, logic r1, logic i0, logic i1,
                                logic g0, logic g1, logic sv, logic v);
        vec_t t;
        t.rst = rst_v; t.r0 = r0; t.r1 = r1; t.i0 = i0; t.i1 = i1;
        t.g0 = g0; t.g1 = g1; t.s = sv; t.v = v;
        tbl.push_back(t);
    endfunction

    // Repeats one expectation n times while cycling the data bits through all patterns.
    function automatic void addRep(int n, logic r0, logic r1, logic g0, logic g1, logic sv, logic v);
        for (int k = 0; k < n; k++) begin
            add(1'b0, r0, r1, k[0], k[1], g0, g1, sv, v);
        end
    endfunction

    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        rst  = t.rst;
        req0 = t.r0;
        req1 = t.r1;
        I0   = t.i0;
        I1   = t.i1;
        expQ.push_back({t.g0, t.g1, t.s, t.v, (t.s ? t.i1 : t.i0)});
    endtask

    task automatic checkOutput(input int idx);
        logic [4:0] exp_v;
        @(posedge clk);
        #1;
        total++;
        if (expQ.size() == 0) begin
            $display("[TB] FAIL row%0d scoreboard empty got={g0,g1,s,v,out}=%b", idx,
                     {gnt0, gnt1, s, valid, out});
        end else begin
            exp_v = expQ.pop_front();
            if ({gnt0, gnt1, s, valid, out} !== exp_v) begin
                $display("[TB] FAIL row%0d {g0,g1,s,v,out} got=%b exp=%b", idx,
                         {gnt0, gnt1, s, valid, out}, exp_v);
            end else begin
                passed++;
            end
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        req0   = 1'b0;
        req1   = 1'b0;
        I0     = 1'b0;
        I1     = 1'b0;

        // Reset held two cycles with both requests high, then released.
        add(1, 1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        // Lone req1 from IDLE, then idle with select held at 1.
        add(0, 0, 1, 0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0, 1, 0, 0, 1);
`ifdef MUX2_ARB_HOLD_LIMIT_EN
        // Both held: four cycles each side, no idle gap.
        addRep(3, 1, 1, 1, 0, 0, 1);
        addRep(4, 1, 1, 0, 1, 1, 1);
        addRep(1, 1, 1, 1, 0, 0, 1);
        // Saturated counter with no competitor, then competitor wins next edge.
        addRep(10, 1, 0, 1, 0, 0, 1);
        addRep(1, 1, 1, 0, 1, 1, 1);
`else
        addRep(8, 1, 1, 1, 0, 0, 1);
        addRep(1, 0, 1, 0, 1, 1, 1);
        addRep(3, 1, 1, 0, 1, 1, 1);
        addRep(1, 1, 0, 1, 0, 0, 1);
        addRep(3, 1, 1, 1, 0, 0, 1);
        addRep(1, 0, 1, 0, 1, 1, 1);
`endif
        // One-cycle reset during G1, then requester 0 is favoured.
        add(1, 1, 1, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 1, 0, 0, 1);
        add(0, 0, 1, 0, 1, 0, 1, 1, 1);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0);
        add(0, 1, 0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 1, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(i);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
